edge_event_unit: RTL and testbench

Multi-channel, parametrised edge detector for asynchronous level inputs. Per channel it synchronises the input, debounces it with a stability counter, and raises a one-cycle event pulse on a rising, falling or either edge as selected by a per-channel mode. Every event also sets a sticky flag that software or a controller clears with a write-1-to-clear strobe. It sits between raw pins or slow status lines and the interrupt/status logic.

---
 rtl/edge_event_unit.sv | 124 ++++++++++++
 tb/tb_edge_event_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_unit.sv
// ---------------------------------------------------------------------------
// edge_event_unit
//
// Multi-channel edge detector for asynchronous level inputs. Each channel
// synchronises its raw input, debounces it with a stability counter and
// raises a one-cycle event pulse on a rising, falling or either edge of the
// accepted level. Every event also sets a sticky flag that is cleared with
// a write-1-to-clear strobe.
//
// Parameters:
//   CH          number of independent channels (>=1)
//   SYNC_STAGES synchroniser flops per channel (>=2)
//   DEBOUNCE    cycles the synchronised input must differ from the
//               accepted level before it is accepted (>=1)
//   CNT_W       debounce counter width (derived)
//
// Ports:
//   clk      in   clock, all state on rising edge
//   rst_n    in   asynchronous active-low reset
//   inp      in   [CH]   raw asynchronous inputs
//   mode     in   [2*CH] per channel {falling_en, rising_en}
//   clr      in   [CH]   write-1-to-clear strobe for sticky
//   level    out  [CH]   debounced accepted level
//   pulse    out  [CH]   one-cycle event pulse
//   sticky   out  [CH]   latched event flag
//   any_evt  out         OR of all sticky bits
// ---------------------------------------------------------------------------
module edge_event_unit #(
   parameter  int CH          = 8,
   parameter  int SYNC_STAGES = 2,
   parameter  int DEBOUNCE    = 4,
   localparam int CNT_W       = $clog2(DEBOUNCE) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [CH-1:0]   inp,
   input  logic [2*CH-1:0] mode,
   input  logic [CH-1:0]   clr,
   output logic [CH-1:0]   level,
   output logic [CH-1:0]   pulse,
   output logic [CH-1:0]   sticky,
   output logic            any_evt
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

   // The new level decides the edge direction: 1 means a rising edge
   // (enabled by mode bit 0), 0 a falling edge (enabled by mode bit 1).
   function automatic logic edge_hit(input logic new_lvl, input logic [1:0] m);
      return new_lvl ? m[0] : m[1];
   endfunction

   logic [CH-1:0]    sync_p [SYNC_STAGES];
   logic [CH-1:0]    s;
   logic [CNT_W-1:0] cnt_q  [CH];
   logic [CNT_W-1:0] cnt_d  [CH];
   logic [CH-1:0]    level_q;
   logic [CH-1:0]    level_d;
   logic [CH-1:0]    evt_d;
   logic [CH-1:0]    pulse_q;
   logic [CH-1:0]    sticky_q;

   // ---- stage 0..SYNC_STAGES-1: synchroniser chain ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_p[k] <= '0;
         end
      end else begin
         sync_p[0] <= inp;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_p[k] <= sync_p[k-1];
         end
      end
   end

   assign s = sync_p[SYNC_STAGES-1];

   // ---- debounce next-state ----
   // Any cycle where s agrees with the accepted level restarts the count,
   // so only a run of DEBOUNCE consecutive differing samples is accepted.
   // Mode is looked at only on the accepting edge.
   always_comb begin
      level_d = level_q;
      evt_d   = '0;
      for (int i = 0; i < CH; i++) begin
         cnt_d[i] = '0;
         if (s[i] != level_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               level_d[i] = s[i];
               evt_d[i]   = edge_hit(s[i], mode[2*i +: 2]);
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // ---- debounce / event register stage ----
   // A set on the same edge as clr wins, so an event is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CH; i++) begin
            cnt_q[i] <= '0;
         end
         level_q  <= '0;
         pulse_q  <= '0;
         sticky_q <= '0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         level_q  <= level_d;
         pulse_q  <= evt_d;
         sticky_q <= (sticky_q & ~clr) | evt_d;
      end
   end

   assign level   = level_q;
   assign pulse   = pulse_q;
   assign sticky  = sticky_q;
   assign any_evt = |sticky_q;

endmodule

// File: tb/tb_edge_event_unit.sv
// ---------------------------------------------------------------------------
// tb_edge_event_unit
//
// Directed bench for edge_event_unit at default parameters (CH=8,
// SYNC_STAGES=2, DEBOUNCE=4). Input changes land between clock edges; an
// accepted change shows on level/pulse/sticky at the 6th edge after it.
// ---------------------------------------------------------------------------
module tb_edge_event_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  inp;
   logic [15:0] mode;
   logic [7:0]  clr;
   logic [7:0]  level;
   logic [7:0]  pulse;
   logic [7:0]  sticky;
   logic        any_evt;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  pulse_seen;
   int          p2cnt;

   edge_event_unit #(
      .CH          (8),
      .SYNC_STAGES (2),
      .DEBOUNCE    (4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .inp     (inp),
      .mode    (mode),
      .clr     (clr),
      .level   (level),
      .pulse   (pulse),
      .sticky  (sticky),
      .any_evt (any_evt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Advance n edges, sampling 1 time unit after each edge.
   task automatic tick(input int n);
      for (int j = 0; j < n; j++) begin
         @(posedge clk);
         #1;
         pulse_seen = pulse_seen | pulse;
         if (pulse[2]) p2cnt++;
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      inp        = '0;
      mode       = '0;
      clr        = '0;
      pulse_seen = '0;
      p2cnt      = 0;

      // Reset state
      tick(2);
      chk("rst_level",  16'(level),   16'h00);
      chk("rst_pulse",  16'(pulse),   16'h00);
      chk("rst_sticky", 16'(sticky),  16'h00);
      chk("rst_any",    16'(any_evt), 16'h0);
      rst_n = 1'b1;
      tick(1);

      // ch0 rising, full latency
      mode = 16'h0001;
      inp  = 8'h01;
      tick(5);
      chk("t1_level_early", 16'(level), 16'h00);
      tick(1);
      chk("t1_level",  16'(level),   16'h01);
      chk("t1_pulse",  16'(pulse),   16'h01);
      chk("t1_sticky", 16'(sticky),  16'h01);
      chk("t1_any",    16'(any_evt), 16'h1);
      tick(1);
      chk("t1_pulse_off", 16'(pulse),  16'h00);
      chk("t1_sticky_hold", 16'(sticky), 16'h01);
      clr = 8'h01;
      tick(1);
      clr = 8'h00;
      chk("t1_clr_sticky", 16'(sticky),  16'h00);
      chk("t1_clr_any",    16'(any_evt), 16'h0);

      // ch1 falling-only: 3-cycle glitch filtered
      mode = 16'h0009;
      pulse_seen = '0;
      inp  = 8'h03;
      tick(3);
      inp  = 8'h01;
      tick(10);
      chk("t2_glitch_level", 16'(level),      16'h01);
      chk("t2_glitch_pulse", 16'(pulse_seen), 16'h00);
      // long high: rising accepted silently, then falling pulses
      inp = 8'h03;
      tick(10);
      chk("t2_rise_level",  16'(level),      16'h03);
      chk("t2_rise_nopulse", 16'(pulse_seen), 16'h00);
      chk("t2_rise_sticky", 16'(sticky),     16'h00);
      inp = 8'h01;
      tick(5);
      chk("t2_fall_early", 16'(level), 16'h03);
      tick(1);
      chk("t2_fall_level",  16'(level),  16'h01);
      chk("t2_fall_pulse",  16'(pulse),  16'h02);
      chk("t2_fall_sticky", 16'(sticky), 16'h02);
      tick(1);
      chk("t2_fall_pulse_off", 16'(pulse), 16'h00);
      clr = 8'h02;
      tick(1);
      clr = 8'h00;
      chk("t2_clr", 16'(sticky), 16'h00);

      // ch2 both edges, 20 cycles apart, clr in between
      mode  = 16'h0039;
      p2cnt = 0;
      inp   = 8'h05;
      tick(6);
      chk("t3_pulse1",  16'(pulse),  16'h04);
      chk("t3_sticky1", 16'(sticky), 16'h04);
      tick(1);
      chk("t3_pulse1_off", 16'(pulse), 16'h00);
      clr = 8'h04;
      tick(1);
      clr = 8'h00;
      chk("t3_clr", 16'(sticky), 16'h00);
      tick(12);
      inp = 8'h01;
      tick(5);
      chk("t3_gap_sticky", 16'(sticky), 16'h00);
      tick(1);
      chk("t3_pulse2",  16'(pulse),  16'h04);
      chk("t3_sticky2", 16'(sticky), 16'h04);
      chk("t3_level2",  16'(level),  16'h01);
      tick(1);
      chk("t3_pulse_count", 16'(p2cnt), 16'd2);

      // ch3: clr on the event edge, set wins; clr next cycle clears
      mode = 16'h0079;
      inp  = 8'h09;
      tick(5);
      clr = 8'h08;
      tick(1);
      chk("t4_pulse",      16'(pulse[3]),  16'h1);
      chk("t4_sticky_set", 16'(sticky[3]), 16'h1);
      tick(1);
      clr = 8'h00;
      chk("t4_sticky_clr", 16'(sticky),  16'h04);

      // ch4: reset asserted mid-debounce
      mode = 16'h0179;
      inp  = 8'h19;
      tick(4);
      rst_n = 1'b0;
      #1;
      chk("t5_async_level",  16'(level),   16'h00);
      chk("t5_async_pulse",  16'(pulse),   16'h00);
      chk("t5_async_sticky", 16'(sticky),  16'h00);
      chk("t5_async_any",    16'(any_evt), 16'h0);
      tick(2);
      rst_n = 1'b1;
      tick(5);
      chk("t5_relatency_early", 16'(level), 16'h00);
      tick(1);
      chk("t5_level",  16'(level),  16'h19);
      chk("t5_pulse",  16'(pulse),  16'h19);
      chk("t5_sticky", 16'(sticky), 16'h19);

      // all inputs high through reset; ch7 mode off tracks level only
      rst_n = 1'b0;
      mode  = 16'h1555;
      inp   = 8'hFF;
      tick(2);
      rst_n = 1'b1;
      pulse_seen = '0;
      tick(5);
      chk("t6_level_early", 16'(level),      16'h00);
      chk("t6_no_early_pulse", 16'(pulse_seen), 16'h00);
      tick(1);
      chk("t6_level",  16'(level),   16'hFF);
      chk("t6_pulse",  16'(pulse),   16'h7F);
      chk("t6_sticky", 16'(sticky),  16'h7F);
      chk("t6_any",    16'(any_evt), 16'h1);
      tick(1);
      chk("t6_pulse_off", 16'(pulse), 16'h00);
      clr = 8'hFF;
      tick(1);
      clr = 8'h00;
      chk("t6_clr_all", 16'(sticky),  16'h00);
      chk("t6_any_off", 16'(any_evt), 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
